// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: datapath widths and the phase encoding used by the
// matrix loader, the multiplier and the result collector.
package spmv_pkg;
    localparam int DW = 64;
    localparam int AW = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;
endpackage

// File: rtl/spmv_result_ram.sv
// Simple dual-port pair buffer, 2**AW x 2*DW, registered single-cycle read.
// Written as a plain array so synthesis maps it onto block RAM.
module spmv_result_ram #(
    parameter int DW = 64,
    parameter int AW = 10
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [2*DW-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [2*DW-1:0] rdata_o
);
    logic [2*DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/spmv_result_collector.sv
// Collects SpMV result pairs into a pair buffer, then streams y[0..2*n_pairs-1]
// in row order over a valid/ready port.
module spmv_result_collector #(
    parameter int DW = spmv_pkg::DW,
    parameter int AW = spmv_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done,
    input  logic [AW:0]   n_pairs,
    input  logic [DW-1:0] op1,
    input  logic [DW-1:0] op2,
    input  logic [AW-1:0] addrext,
    input  logic          valid,
    input  logic          zeros,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          complete,
    output logic          err
);
    import spmv_pkg::*;

    localparam int NP = 2**AW;
    localparam logic [AW:0] ONE = 1;

    state_e          state_q;
    logic [NP-1:0]   bitmap_q;
    logic [AW:0]     cnt_q, np_q, rd_ptr_q, out_idx_q;
    logic            avail_q, bm_rd_q, out_valid_q, complete_q, err_q;
    logic [DW-1:0]   out_data_q, odd_q;
    logic [2*DW-1:0] rdata, pair, wdata;

    logic        ev, in_range, we, re, xfer, ld_even, last_xfer;
    logic [AW:0] cnt_d, last_idx;

    assign ev       = valid | zeros;
    assign in_range = {1'b0, addrext} < np_q;
    assign we       = (state_q == ST_COLLECT) && done && ev && in_range;
    assign wdata    = zeros ? '0 : {op2, op1};
    assign cnt_d    = cnt_q + ONE;
    assign last_idx = {np_q[AW-1:0], 1'b0} - ONE;

    // rdata doubles as the prefetch buffer: the next pair is read as soon as
    // the current even element is loaded, so it is ready when the odd one leaves.
    assign xfer      = out_valid_q && out_ready;
    assign ld_even   = (state_q == ST_DRAIN) && avail_q &&
                       (!out_valid_q || (xfer && out_idx_q[0]));
    assign re        = (state_q == ST_DRAIN) && (rd_ptr_q < np_q) && (!avail_q || ld_even);
    assign last_xfer = xfer && (out_idx_q == last_idx);
    assign pair      = bm_rd_q ? rdata : '0;

    spmv_result_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (addrext),
        .wdata_i (wdata),
        .re_i    (re),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitmap_q    <= '0;
            cnt_q       <= '0;
            np_q        <= '0;
            rd_ptr_q    <= '0;
            avail_q     <= 1'b0;
            bm_rd_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            odd_q       <= '0;
            complete_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (re) bm_rd_q <= bitmap_q[rd_ptr_q[AW-1:0]];
            unique case (state_q)
                ST_IDLE: begin
                    if (done) begin
                        state_q  <= ST_COLLECT;
                        bitmap_q <= '0;
                        cnt_q    <= '0;
                        np_q     <= n_pairs;
                        err_q    <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (!done) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (ev) begin
                        if (!in_range) begin
                            err_q <= 1'b1;
                        end else begin
                            bitmap_q[addrext] <= 1'b1;
                            if (!bitmap_q[addrext]) begin
                                cnt_q <= cnt_d;
                                if (cnt_d == np_q) begin
                                    state_q  <= ST_DRAIN;
                                    rd_ptr_q <= '0;
                                    avail_q  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (re) rd_ptr_q <= rd_ptr_q + ONE;
                    avail_q <= re | (avail_q & ~ld_even);
                    if (ld_even) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= pair[DW-1:0];
                        odd_q       <= pair[2*DW-1:DW];
                        out_idx_q   <= out_valid_q ? out_idx_q + ONE : '0;
                    end else if (xfer) begin
                        if (last_xfer) begin
                            out_valid_q <= 1'b0;
                            complete_q  <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (!out_idx_q[0]) begin
                            out_data_q <= odd_q;
                            out_idx_q  <= out_idx_q + ONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!done) begin
                        complete_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign complete  = complete_q;
    assign err       = err_q;
endmodule
